// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: run sequencer between the sample BRAM, a transposed FIR
// and its output FIFO. Each run resets the FIR, streams SAMPLE_COUNT samples
// followed by TAP_COUNT-1 zeros, and opens the FIFO write window (o_sig_comp
// low) for exactly the full-convolution output length.
module fir_stream_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int SAMPLE_COUNT = 1024,
  parameter int TAP_COUNT    = 65,
  parameter int RST_CYCLES   = 2,
  parameter int WREN_SKEW    = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic                         i_start,
  input  logic                         i_abort,
  input  logic                         i_fifo_empty,
  input  logic                         i_fifo_full,
  output logic [ADDR_WIDTH-1:0]        o_bram_addr,
  output logic                         o_bram_rden,
  input  logic [DATA_WIDTH-1:0]        i_bram_data,
  output logic signed [DATA_WIDTH-1:0] o_fir_datain,
  output logic                         o_fir_rstn,
  output logic                         o_sig_comp,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_start_err,
  output logic                         o_overflow
);

  // Window length equals the full convolution output length.
  localparam int WIN_LEN   = SAMPLE_COUNT + TAP_COUNT - 1;
  localparam int WIN_W     = $clog2(WIN_LEN) + 1;
  localparam int FLUSH_LEN = TAP_COUNT - 1;
  localparam int FLUSH_W   = $clog2(FLUSH_LEN) + 1;
  localparam int CLR_W     = $clog2(RST_CYCLES) + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_READ  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t                        state_q, state_d;
  logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
  logic                          rden_q, rden_d;
  logic signed [DATA_WIDTH-1:0]  datain_q, datain_d;
  logic                          fir_rstn_q, fir_rstn_d;
  logic                          sig_comp_q, sig_comp_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          start_err_q, start_err_d;
  logic                          overflow_q, overflow_d;
  // BRAM data is valid the cycle after a read was issued.
  logic                          rd_valid_q, rd_valid_d;
  // Marks that the next captured sample is sample 0 of the run.
  logic                          first_q, first_d;
  logic [CLR_W-1:0]              clr_cnt_q, clr_cnt_d;
  logic [FLUSH_W-1:0]            flush_cnt_q, flush_cnt_d;
  logic [WIN_W-1:0]              win_cnt_q, win_cnt_d;
  logic                          win_closed_q, win_closed_d;

  logic abort_s;
  logic capture_s;
  logic trig_s;
  logic open_s;

  assign abort_s   = i_abort && (state_q != ST_IDLE);
  assign capture_s = rd_valid_q && ((state_q == ST_READ) || (state_q == ST_FLUSH));
  assign trig_s    = capture_s && first_q;

  // The write window opens WREN_SKEW cycles after sample 0 reaches the FIR.
  if (WREN_SKEW == 0) begin : g_no_skew
    assign open_s = trig_s;
  end else begin : g_skew
    logic [WREN_SKEW-1:0] dly_q;

    // Delay line from "sample 0 captured" to "open write window".
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        dly_q <= {WREN_SKEW{1'b0}};
      end else if (abort_s) begin
        dly_q <= {WREN_SKEW{1'b0}};
      end else begin
        dly_q <= (dly_q << 1) | WREN_SKEW'(trig_s);
      end
    end

    assign open_s = dly_q[WREN_SKEW-1];
  end

  // State and registered-output update.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= ST_IDLE;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      rden_q       <= 1'b0;
      datain_q     <= {DATA_WIDTH{1'b0}};
      fir_rstn_q   <= 1'b0;
      sig_comp_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      start_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      first_q      <= 1'b0;
      clr_cnt_q    <= {CLR_W{1'b0}};
      flush_cnt_q  <= {FLUSH_W{1'b0}};
      win_cnt_q    <= {WIN_W{1'b0}};
      win_closed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rden_q       <= rden_d;
      datain_q     <= datain_d;
      fir_rstn_q   <= fir_rstn_d;
      sig_comp_q   <= sig_comp_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      start_err_q  <= start_err_d;
      overflow_q   <= overflow_d;
      rd_valid_q   <= rd_valid_d;
      first_q      <= first_d;
      clr_cnt_q    <= clr_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      win_cnt_q    <= win_cnt_d;
      win_closed_q <= win_closed_d;
    end
  end

  // Next-state, sample path, write window and status computation.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rden_d       = rden_q;
    fir_rstn_d   = fir_rstn_q;
    sig_comp_d   = sig_comp_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    start_err_d  = 1'b0;
    rd_valid_d   = rden_q;
    first_d      = first_q;
    clr_cnt_d    = clr_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    win_cnt_d    = win_cnt_q;
    win_closed_d = win_closed_q;

    // Zeros fill every cycle without a fresh BRAM sample, which also forms
    // the flush tail.
    if (capture_s) begin
      datain_d = i_bram_data;
      first_d  = 1'b0;
    end else begin
      datain_d = {DATA_WIDTH{1'b0}};
    end

    // A full FIFO while writes are enabled means output samples were lost.
    if (!sig_comp_q && i_fifo_full) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    if (abort_s) begin
      state_d      = ST_IDLE;
      rden_d       = 1'b0;
      datain_d     = {DATA_WIDTH{1'b0}};
      fir_rstn_d   = 1'b0;
      sig_comp_d   = 1'b1;
      busy_d       = 1'b0;
      rd_valid_d   = 1'b0;
      first_d      = 1'b0;
      win_cnt_d    = {WIN_W{1'b0}};
      win_closed_d = 1'b0;
    end else begin
      // Window counter runs on its own, independent of the FSM state.
      if (open_s) begin
        sig_comp_d = 1'b0;
        win_cnt_d  = WIN_W'(WIN_LEN);
      end else if (!sig_comp_q) begin
        win_cnt_d = win_cnt_q - WIN_W'(1);
        if (win_cnt_q == WIN_W'(1)) begin
          sig_comp_d   = 1'b1;
          win_closed_d = 1'b1;
        end else begin
          sig_comp_d = 1'b0;
        end
      end else begin
        sig_comp_d = 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          fir_rstn_d = 1'b0;
          if (i_start && !i_abort) begin
            if (i_fifo_empty) begin
              state_d      = ST_CLEAR;
              busy_d       = 1'b1;
              overflow_d   = 1'b0;
              clr_cnt_d    = {CLR_W{1'b0}};
              win_closed_d = 1'b0;
            end else begin
              start_err_d = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_q == CLR_W'(RST_CYCLES - 1)) begin
            state_d    = ST_READ;
            fir_rstn_d = 1'b1;
            addr_d     = {ADDR_WIDTH{1'b0}};
            rden_d     = 1'b1;
            first_d    = 1'b1;
          end else begin
            clr_cnt_d = clr_cnt_q + CLR_W'(1);
          end
        end
        ST_READ: begin
          if (addr_q == ADDR_WIDTH'(SAMPLE_COUNT - 1)) begin
            rden_d      = 1'b0;
            state_d     = ST_FLUSH;
            flush_cnt_d = {FLUSH_W{1'b0}};
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
        ST_FLUSH: begin
          // Count zero cycles driven after the last sample has been presented.
          if (!capture_s) begin
            flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
            if (flush_cnt_q == FLUSH_W'(FLUSH_LEN - 1)) begin
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_FLUSH;
            end
          end else begin
            flush_cnt_d = flush_cnt_q;
          end
        end
        ST_DRAIN: begin
          if (win_closed_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_DONE: begin
          state_d    = ST_IDLE;
          fir_rstn_d = 1'b0;
        end
        default: begin
          state_d    = ST_IDLE;
          rden_d     = 1'b0;
          fir_rstn_d = 1'b0;
          sig_comp_d = 1'b1;
          busy_d     = 1'b0;
        end
      endcase
    end
  end

  assign o_bram_addr  = addr_q;
  assign o_bram_rden  = rden_q;
  assign o_fir_datain = datain_q;
  assign o_fir_rstn   = fir_rstn_q;
  assign o_sig_comp   = sig_comp_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_start_err  = start_err_q;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Self-checking bench for fir_stream_ctrl with SAMPLE_COUNT=8, TAP_COUNT=4.
// Each run is recorded cycle by cycle after the start edge and compared with
// expected output windows derived from the run timing rules.
module tb_fir_stream_ctrl;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int S  = 8;
  localparam int T  = 4;
  localparam int R  = 2;
  localparam int SK = 2;
  // Cycle offsets counted from the edge that accepts the start (k=1 is the
  // first cycle after it).
  localparam int R0   = R + 1;          // first READ cycle
  localparam int DAT0 = R0 + 2;         // sample 0 on o_fir_datain
  localparam int LOW0 = DAT0 + SK;      // first write-window cycle
  localparam int LOWN = LOW0 + S + T - 2; // last write-window cycle
  localparam int DK   = LOWN + 2;       // o_done cycle
  localparam int NCYC = DK + 3;

  logic clk, rstn, start, abort, fifo_empty, fifo_full;
  logic [AW-1:0] bram_addr;
  logic bram_rden;
  logic [DW-1:0] bram_data;
  logic [DW-1:0] fir_datain;
  logic fir_rstn, sig_comp, busy, done, start_err, overflow;

  logic [DW-1:0] mem [0:S-1];
  bit full_arr [0:NCYC];
  bit xstart [0:NCYC];

  int n_checks = 0;
  int n_fail = 0;

  fir_stream_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SAMPLE_COUNT(S),
    .TAP_COUNT(T), .RST_CYCLES(R), .WREN_SKEW(SK)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_abort(abort),
    .i_fifo_empty(fifo_empty), .i_fifo_full(fifo_full),
    .o_bram_addr(bram_addr), .o_bram_rden(bram_rden), .i_bram_data(bram_data),
    .o_fir_datain(fir_datain), .o_fir_rstn(fir_rstn), .o_sig_comp(sig_comp),
    .o_busy(busy), .o_done(done), .o_start_err(start_err), .o_overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency BRAM model.
  always @(posedge clk) begin
    if (bram_rden) bram_data <= mem[bram_addr[2:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, " addr"}, 32'(bram_addr), 32'd0);
    check_eq({tag, " rden"}, 32'(bram_rden), 32'd0);
    check_eq({tag, " datain"}, 32'(fir_datain), 32'd0);
    check_eq({tag, " fir_rstn"}, 32'(fir_rstn), 32'd0);
    check_eq({tag, " sig_comp"}, 32'(sig_comp), 32'd1);
    check_eq({tag, " busy"}, 32'(busy), 32'd0);
    check_eq({tag, " done"}, 32'(done), 32'd0);
    check_eq({tag, " start_err"}, 32'(start_err), 32'd0);
    check_eq({tag, " overflow"}, 32'(overflow), 32'd0);
  endtask

  task automatic clear_stim();
    for (int i = 0; i <= NCYC; i++) begin
      full_arr[i] = 1'b0;
      xstart[i] = 1'b0;
    end
  endtask

  // Start a run and compare every output for NCYC cycles. ka>0 aborts in cycle ka.
  task automatic run_trace(input string name, input int ka);
    bit live, e_rden, e_low, e_frst, e_busy, e_done, e_ovf;
    logic [31:0] e_dat;
    e_ovf = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0; fifo_full = 1'b0;
    for (int k = 1; k <= NCYC; k++) begin
      @(posedge clk); #1;
      start = xstart[k];
      abort = (k == ka);
      fifo_full = full_arr[k];
      @(negedge clk);
      live   = (ka == 0) || (k <= ka);
      e_rden = live && (k >= R0) && (k <= R0 + S - 1);
      e_dat  = (live && (k >= DAT0) && (k <= DAT0 + S - 1)) ? 32'(mem[k - DAT0]) : 32'd0;
      e_low  = live && (k >= LOW0) && (k <= LOWN);
      e_frst = live && (k >= R0) && (k <= DK);
      e_busy = live && (k >= 1) && (k <= DK - 1);
      e_done = live && (k == DK);
      check_eq($sformatf("%s k=%0d rden", name, k), 32'(bram_rden), 32'(e_rden));
      if (e_rden)
        check_eq($sformatf("%s k=%0d addr", name, k), 32'(bram_addr), 32'(k - R0));
      check_eq($sformatf("%s k=%0d datain", name, k), 32'(fir_datain), e_dat);
      check_eq($sformatf("%s k=%0d fir_rstn", name, k), 32'(fir_rstn), 32'(e_frst));
      check_eq($sformatf("%s k=%0d sig_comp", name, k), 32'(sig_comp), 32'(!e_low));
      check_eq($sformatf("%s k=%0d busy", name, k), 32'(busy), 32'(e_busy));
      check_eq($sformatf("%s k=%0d done", name, k), 32'(done), 32'(e_done));
      check_eq($sformatf("%s k=%0d start_err", name, k), 32'(start_err), 32'd0);
      check_eq($sformatf("%s k=%0d overflow", name, k), 32'(overflow), 32'(e_ovf));
      // Overflow becomes visible the cycle after full is seen inside the window.
      e_ovf = e_ovf | (e_low & full_arr[k]);
    end
    start = 1'b0; abort = 1'b0; fifo_full = 1'b0;
  endtask

  initial begin
    int ka;
    rstn = 1'b0; start = 1'b0; abort = 1'b0;
    fifo_empty = 1'b1; fifo_full = 1'b0;
    for (int i = 0; i < S; i++) mem[i] = 16'(i + 1);
    clear_stim();

    @(negedge clk);
    check_reset_values("reset");
    #2 rstn = 1'b1;

    // Nominal run with samples 1..8.
    run_trace("nominal", 0);

    // One full cycle inside the window; overflow must hold through done.
    full_arr[10] = 1'b1;
    run_trace("overflow", 0);
    clear_stim();
    // Next accepted start clears overflow (checked at k=1).
    run_trace("ovf_clear", 0);

    // Abort on the 4th READ cycle.
    run_trace("abort", R0 + 3);

    // Start pulse during DRAIN must be ignored.
    xstart[16] = 1'b1;
    run_trace("busy_start", 0);
    clear_stim();

    // Rejected start with a non-empty FIFO.
    fifo_empty = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check_eq("reject start_err", 32'(start_err), 32'd1);
    check_eq("reject busy", 32'(busy), 32'd0);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check_eq($sformatf("reject k=%0d start_err", k), 32'(start_err), 32'd0);
      check_eq($sformatf("reject k=%0d rden", k), 32'(bram_rden), 32'd0);
      check_eq($sformatf("reject k=%0d busy", k), 32'(busy), 32'd0);
    end
    fifo_empty = 1'b1;

    // Asynchronous reset in the middle of FLUSH.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #2 rstn = 1'b0;
    #1 check_reset_values("async_rst");
    @(negedge clk);
    check_reset_values("async_rst_hold");
    #2 rstn = 1'b1;
    run_trace("after_rst", 0);

    // Randomized runs: random data, full pulses, busy starts and aborts.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < S; i++) mem[i] = 16'($urandom);
      ka = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DK - 1)) : 0;
      for (int k = 0; k <= NCYC; k++) begin
        full_arr[k] = ($urandom_range(0, 5) == 0);
        xstart[k] = (k >= 1) && (k <= DK - 1) && ((ka == 0) || (k < ka)) &&
                    ($urandom_range(0, 7) == 0);
      end
      run_trace($sformatf("rnd%0d", r), ka);
      repeat (2) @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_stream_ctrl.md
Name: fir_stream_ctrl

Overview:
- Sequencer that sits between the sample BRAM, the transposed FIR and the output FIFO.
- On a start request it:
  - holds the FIR in reset for coefficient load;
  - streams SAMPLE_COUNT stored samples into the FIR at one sample per clock;
  - appends TAP_COUNT-1 zero samples to flush the filter tail.
- It drives the FIR's sig_comp input so the FIFO receives exactly the full-convolution output window, then reports completion.
- The FIR has no clock enable, so the block does not stall mid-run. Instead it admits a run only when the FIFO is empty and flags any overflow.

Parameters:
- DATA_WIDTH, 16, sample width
- ADDR_WIDTH, 10, BRAM address width
- SAMPLE_COUNT, 1024, samples per run (2..2^ADDR_WIDTH)
- TAP_COUNT, 65, FIR tap count (>=2)
- RST_CYCLES, 2, cycles o_fir_rstn is held low before streaming (>=1)
- WREN_SKEW, 2, cycles from a sample on o_fir_datain to its first effect on FIFO write-enable gating

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_start  in  1  run request, single-cycle pulse
- i_abort  in  1  abort run, single-cycle pulse
- i_fifo_empty  in  1  output FIFO empty
- i_fifo_full  in  1  output FIFO full
- o_bram_addr  out  ADDR_WIDTH  sample read address
- o_bram_rden  out  1  BRAM read enable
- i_bram_data  in  DATA_WIDTH  BRAM read data, valid 1 cycle after o_bram_rden
- o_fir_datain  out  DATA_WIDTH  registered signed sample to FIR
- o_fir_rstn  out  1  FIR synchronous reset, active-low
- o_sig_comp  out  1  high suppresses FIR FIFO writes
- o_busy  out  1  run in progress
- o_done  out  1  one-cycle pulse at run completion
- o_start_err  out  1  one-cycle pulse when a start is rejected
- o_overflow  out  1  sticky: i_fifo_full seen while the write window was open

Behaviour:
- Async reset values:
  - state=IDLE, o_bram_addr=0, o_bram_rden=0, o_fir_datain=0;
  - o_fir_rstn=0, o_sig_comp=1;
  - o_busy=0, o_done=0, o_start_err=0, o_overflow=0.
- States: IDLE, CLEAR, READ, FLUSH, DRAIN, DONE.
- IDLE:
  - o_fir_rstn=0, o_sig_comp=1, o_fir_datain=0.
  - i_start with i_fifo_empty=1: go to CLEAR, set o_busy=1, clear o_overflow.
  - i_start with i_fifo_empty=0: pulse o_start_err, stay in IDLE.
- CLEAR:
  - o_fir_rstn=0 for exactly RST_CYCLES cycles.
  - Then o_fir_rstn=1 and go to READ with o_bram_addr=0.
- READ:
  - o_bram_rden=1 every cycle; o_bram_addr counts 0..SAMPLE_COUNT-1.
  - After issuing the last address, rden drops and the state goes to FLUSH.
  - o_fir_datain <= i_bram_data on the cycle after each rden, giving 2 cycles from address to o_fir_datain.
- FLUSH:
  - o_fir_datain=0 for TAP_COUNT-1 cycles, counted from the cycle after the last BRAM sample appears.
  - The sample stream on o_fir_datain is therefore SAMPLE_COUNT data cycles followed by TAP_COUNT-1 zero cycles, with no gaps.
- Write window:
  - o_sig_comp goes low WREN_SKEW cycles after sample 0 first appears on o_fir_datain.
  - It stays low for exactly SAMPLE_COUNT+TAP_COUNT-1 consecutive cycles, then returns high.
  - A window counter tracks it, independent of state.
- DRAIN: wait until o_sig_comp has returned high, then go to DONE.
- DONE: o_done=1 for one cycle, o_busy=0, next state IDLE. o_fir_rstn returns low in IDLE.
- Overflow: any cycle with o_sig_comp=0 and i_fifo_full=1 sets o_overflow. It stays set until the next accepted start or reset.
- Abort: i_abort in any non-IDLE state takes effect on the next edge:
  - o_sig_comp=1, o_bram_rden=0, o_fir_datain=0, o_fir_rstn=0;
  - go to IDLE with no o_done pulse; o_busy=0.
- Simultaneous events:
  - i_abort and i_start in the same cycle: abort wins, start ignored.
  - i_start while busy: ignored, no error pulse.
- Reset mid-run: all outputs take reset values immediately. The run is lost and no o_done is produced.
- Counters are sized with $clog2 of their terminal values plus one bit; no wrap-around occurs within a run.

Test Plan (SAMPLE_COUNT=8, TAP_COUNT=4, RST_CYCLES=2, WREN_SKEW=2):
- Nominal:
  - Stimulus: BRAM holds 1..8, i_fifo_empty=1, i_start pulse.
  - Response:
    - o_fir_rstn low 2 cycles after start;
    - addr 0..7 with rden high 8 cycles;
    - o_fir_datain = 1,2,...,8,0,0,0 contiguous;
    - o_sig_comp low exactly 11 cycles, starting 2 cycles after value 1 appears;
    - single o_done pulse; o_busy falls with it.
- Rejected start: i_fifo_empty=0 with i_start -> o_start_err 1 cycle, state IDLE, o_bram_rden never asserts.
- Overflow:
  - Nominal run with i_fifo_full=1 for one cycle inside the window -> o_overflow=1 through o_done.
  - Next accepted start clears o_overflow to 0.
- Abort: i_abort on the 4th READ cycle -> next cycle o_bram_rden=0, o_sig_comp=1, o_fir_rstn=0, o_fir_datain=0, IDLE, no o_done.
- Async reset: i_rstn low mid-FLUSH, asynchronously between clock edges -> all outputs at reset values before the next clock edge. A later start runs a full nominal sequence.
- Busy start: i_start pulsed during DRAIN -> ignored, no o_start_err, exactly one o_done.
